data_memory: RTL and testbench
==============================

Name: data_memory

Overview:
- Synchronous single-port random-access data memory: 16 words × 8 bits by default.
- Sits on the microprocessor's address/data buses and is addressed by the CPU.
- Separate input and output data buses.
- Accesses are gated by an enable and a read/write select, all sampled on the rising clock edge.

Parameters:
- ADDR_WIDTH, 4, address bus width; depth = 2**ADDR_WIDTH words (16 by default).
- DATA_WIDTH, 8, word width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- address_bus  input  ADDR_WIDTH  word address for the current access.
- mem_enable  input  1  access enable; 0 = idle.
- read_write  input  1  access type: 1 = read, 0 = write.
- data_bus_in  input  DATA_WIDTH  write data.
- data_bus_out  output  DATA_WIDTH  registered read data.

Behaviour:
- Reset is synchronous, active-high, and sampled on the rising edge of clk.
- While rst = 1, at every edge:
  - all 2**ADDR_WIDTH storage words clear to 0;
  - data_bus_out clears to 0;
  - the enable, read/write and address inputs are ignored.
- Reset has priority over any access in the same cycle:
  - a write coinciding with reset is discarded;
  - a read coinciding with reset returns 0.
- Operation table, evaluated at each rising edge with rst = 0:
  - mem_enable = 0: no storage change; data_bus_out holds its previous value.
  - mem_enable = 1, read_write = 1 (read): data_bus_out <= mem[address_bus]; storage unchanged.
  - mem_enable = 1, read_write = 0 (write): mem[address_bus] <= data_bus_in; data_bus_out holds its previous value (no write-through).
- Read latency is 1 cycle. Address and controls are sampled at edge N; data is valid on data_bus_out after edge N and stays stable until the next read or reset.
- Write latency is 1 cycle. A write at edge N is visible to a read sampled at edge N+1.
- Back-to-back accesses, one per cycle, are supported with no bubbles. Consecutive reads to different addresses return each word on successive cycles.
- Address range is full, with no wrap logic needed: every address 0..2**ADDR_WIDTH-1 is valid and there are no out-of-range cases.
- Only the addressed word changes on a write; all other words retain their contents indefinitely while rst = 0.
- Inputs are don't-care when mem_enable = 0; toggling them causes no state change.
- data_bus_out is a plain driven register: no tri-state and no combinational path from inputs to outputs.
- Storage is an array of DATA_WIDTH-bit registers with synchronous clear. It is not required to map to inferred block RAM.

Test Plan:
- Reset clear: hold rst = 1 for 2 cycles, then read addresses 0, 5 and 15 -> data_bus_out = 0x00 for each, one cycle after each read is sampled.
- Read/write/readback: read addr 5 -> out 0x00; write 0x0F to addr 5 (out stays 0x00 during the write); read addr 5 at the next edge -> out 0x0F.
- Enable gating: after out = 0x0F, drop mem_enable and present a write of 0xAA to addr 5 plus address changes for 3 cycles -> out stays 0x0F; a later read of addr 5 returns 0x0F.
- Independence and boundaries: write 0x11 to addr 0, 0x22 to addr 15 and 0x33 to addr 7 on back-to-back cycles. Then read 0, 15, 7, 1 back-to-back -> outputs 0x11, 0x22, 0x33, 0x00 on consecutive cycles.
- Reset mid-operation: assert rst in the same cycle as a write of 0x55 to addr 3 -> out = 0x00; after release, reading addr 3 and addr 7 both return 0x00.
- Overwrite: write 0xFF then 0x01 to addr 9 in consecutive cycles, then read addr 9 -> out 0x01.

Source files
------------

// File: rtl/data_memory.sv
// Single-port 2**ADDR_WIDTH x DATA_WIDTH data memory with synchronous clear; 1-cycle registered read, 1-cycle write.
// No backpressure: one access per cycle when mem_enable is high, and data_bus_out holds between reads.
module data_memory #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] address_bus,
    input  logic                  mem_enable,
    input  logic                  read_write,
    input  logic [DATA_WIDTH-1:0] data_bus_in,
    output logic [DATA_WIDTH-1:0] data_bus_out
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  w_rd_en;
    logic                  w_wr_en;

    assign w_rd_en = mem_enable &  read_write;
    assign w_wr_en = mem_enable & ~read_write;

    // Reset wins over any access presented in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[address_bus] <= data_bus_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (w_rd_en) begin
            r_data_out <= r_mem[address_bus];
        end
    end

    assign data_bus_out = r_data_out;

endmodule

// File: tb/tb_data_memory.sv
// Directed-vector bench for data_memory with hand-computed expected read data.
module tb_data_memory;

    logic       clk;
    logic       rst;
    logic [3:0] address_bus;
    logic       mem_enable;
    logic       read_write;
    logic [7:0] data_bus_in;
    logic [7:0] data_bus_out;

    int n_checks;
    int n_pass;

    data_memory #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .address_bus  (address_bus),
        .mem_enable   (mem_enable),
        .read_write   (read_write),
        .data_bus_in  (data_bus_in),
        .data_bus_out (data_bus_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare the output.
    task automatic cyc(input string tag, input logic r, input logic en, input logic rw,
                       input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp);
        @(negedge clk);
        rst         = r;
        mem_enable  = en;
        read_write  = rw;
        address_bus = a;
        data_bus_in = d;
        @(posedge clk);
        #1;
        check(tag, data_bus_out, exp);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        rst         = 1'b1;
        mem_enable  = 1'b0;
        read_write  = 1'b1;
        address_bus = 4'd0;
        data_bus_in = 8'h00;

        // Reset clear
        cyc("rst_cyc0", 1'b1, 1'b0, 1'b1, 4'd0, 8'h00, 8'h00);
        cyc("rst_cyc1", 1'b1, 1'b0, 1'b1, 4'd0, 8'h00, 8'h00);
        cyc("rd0_after_rst",  1'b0, 1'b1, 1'b1, 4'd0,  8'h00, 8'h00);
        cyc("rd5_after_rst",  1'b0, 1'b1, 1'b1, 4'd5,  8'h00, 8'h00);
        cyc("rd15_after_rst", 1'b0, 1'b1, 1'b1, 4'd15, 8'h00, 8'h00);

        // Read / write / readback
        cyc("rd5_empty",   1'b0, 1'b1, 1'b1, 4'd5, 8'h00, 8'h00);
        cyc("wr5_no_thru", 1'b0, 1'b1, 1'b0, 4'd5, 8'h0F, 8'h00);
        cyc("rd5_0f",      1'b0, 1'b1, 1'b1, 4'd5, 8'h00, 8'h0F);

        // Enable gating: disabled writes and address changes do nothing
        cyc("idle_wr_a5", 1'b0, 1'b0, 1'b0, 4'd5,  8'hAA, 8'h0F);
        cyc("idle_wr_a3", 1'b0, 1'b0, 1'b0, 4'd3,  8'hAA, 8'h0F);
        cyc("idle_rd_a9", 1'b0, 1'b0, 1'b1, 4'd9,  8'hAA, 8'h0F);
        cyc("rd5_kept",   1'b0, 1'b1, 1'b1, 4'd5,  8'h00, 8'h0F);

        // Independence and boundary addresses, back-to-back
        cyc("wr0_11",  1'b0, 1'b1, 1'b0, 4'd0,  8'h11, 8'h0F);
        cyc("wr15_22", 1'b0, 1'b1, 1'b0, 4'd15, 8'h22, 8'h0F);
        cyc("wr7_33",  1'b0, 1'b1, 1'b0, 4'd7,  8'h33, 8'h0F);
        cyc("rd0",     1'b0, 1'b1, 1'b1, 4'd0,  8'h00, 8'h11);
        cyc("rd15",    1'b0, 1'b1, 1'b1, 4'd15, 8'h00, 8'h22);
        cyc("rd7",     1'b0, 1'b1, 1'b1, 4'd7,  8'h00, 8'h33);
        cyc("rd1",     1'b0, 1'b1, 1'b1, 4'd1,  8'h00, 8'h00);
        cyc("rd5_still", 1'b0, 1'b1, 1'b1, 4'd5, 8'h00, 8'h0F);

        // Reset mid-operation discards a concurrent write and clears storage
        cyc("rst_with_wr3", 1'b1, 1'b1, 1'b0, 4'd3, 8'h55, 8'h00);
        cyc("rd3_after",    1'b0, 1'b1, 1'b1, 4'd3, 8'h00, 8'h00);
        cyc("rd7_cleared",  1'b0, 1'b1, 1'b1, 4'd7, 8'h00, 8'h00);
        cyc("rd5_cleared",  1'b0, 1'b1, 1'b1, 4'd5, 8'h00, 8'h00);

        // Overwrite
        cyc("wr9_ff", 1'b0, 1'b1, 1'b0, 4'd9, 8'hFF, 8'h00);
        cyc("wr9_01", 1'b0, 1'b1, 1'b0, 4'd9, 8'h01, 8'h00);
        cyc("rd9_01", 1'b0, 1'b1, 1'b1, 4'd9, 8'h00, 8'h01);

        // A read coinciding with reset returns zero
        cyc("rst_with_rd9", 1'b1, 1'b1, 1'b1, 4'd9, 8'h00, 8'h00);
        cyc("rd9_cleared",  1'b0, 1'b1, 1'b1, 4'd9, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
